load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the data memory port: accepts load/store requests from the execute stage and generates word address, byte enables, lane-replicated store data and write enable. It waits out the memory's fixed read latency, then returns aligned and sign- or zero-extended load data through a valid/ready handshake. It sits between the RV32I execute stage and `data_memory`, including the memory-mapped IO windows at word-address bits 10 and 11.

## Interface
Parameters:
- ADDR_WIDTH, 12, word-address width of the data memory port
- READ_LATENCY, 2, clock edges from request acceptance to a valid `mem_q`; covers the slower IO read path. Legal values 1–7.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when both high
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_address  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid; access suppressed
- mem_address  out  ADDR_WIDTH  word address = req_address[ADDR_WIDTH+1:2]
- mem_byteena  out  4  byte enables
- mem_data  out  32  lane-replicated store data
- mem_wren  out  1  write enable
- mem_q  in  32  memory read data

## Operation
- States: IDLE, READ_WAIT, RESP. `req_ready` = (state == IDLE) && !reset.
- In IDLE, `mem_*` outputs are combinational from `req_*`, because the memory registers its inputs. `mem_wren` = req_valid && req_ready && req_write && !fault.
- Byte offset off = req_address[1:0].
  - SB: byteena = 4'b0001 << off; data = {4{wdata[7:0]}}.
  - SH: byteena = off[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - SW: 4'b1111; data = wdata.
  - Loads: byteena 4'b1111.
- Fault conditions: funct3 not in the legal set for the direction (loads 3'b011/110/111; stores 3'b011 and above). Misalignment faults are governed by Configuration. A faulted request is accepted with mem_wren = 0 and goes straight to RESP with rsp_fault = 1.
- Store, no fault: IDLE → RESP.
- Load, no fault: IDLE → READ_WAIT.
  - Funct3 and off are latched on acceptance.
  - A 3-bit counter counts READ_LATENCY edges; `mem_q` is captured on the final edge, then state moves to RESP.
- Load extraction from the captured word:
  - Byte = word[8*off +: 8]; half = word[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP lasts one cycle: rsp_valid = 1, then IDLE. No request is accepted in RESP.
- Outside IDLE, `mem_wren` = 0. `mem_address`, `mem_byteena` and `mem_data` are don't-care.

## Timing
- Acceptance edge E0. Store response: rsp_valid high in the cycle after E0. Load response: rsp_valid high in the cycle after E(READ_LATENCY), so 3 cycles after E0 by default.
- Back-to-back throughput: store every 2 cycles; load every READ_LATENCY+2 cycles.
- Reset values: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_fault 0. req_ready and mem_wren are forced 0 during reset.
- Reset mid-load: the pending result is dropped and no rsp_valid is produced. The unit is ready the cycle after reset deasserts.
- rsp_rdata and rsp_fault hold their value outside RESP and are only meaningful with rsp_valid.

## Configuration
- Macro LSU_MISALIGN_TRAP_EN.
  - Defined: halfword with off[0] = 1, or word with off != 0, faults. No memory write occurs, and rsp_fault = 1.
  - Undefined: misaligned accesses are silently aligned. Halfword uses off[1] only; word ignores off. Faults arise only from illegal funct3.

## Structure
- Shared package `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, IO window bit positions.
- One combinational sub-module, `load_extract`: inputs word, offset, funct3; output extended 32-bit value. Reused by the bench model.

## Test plan
- SB addr 0x0000_0406, wdata 0x0000_00A5 → mem_address 0x101, byteena 4'b0100, data 0xA5A5A5A5, mem_wren 1 for one cycle; rsp_valid one cycle later, rsp_fault 0.
- LB addr 0x3, mem_q 0x80FF_0000 → rsp_rdata 0xFFFF_FF80 in the cycle after E2; LBU same stimulus → 0x0000_0080.
- LH addr 0x2, mem_q 0x8001_1234 → rsp_rdata 0xFFFF_8001; LW addr 0x2000 (IO window, word 0x800) → mem_address 0x800 and rdata equal to mem_q.
- SW addr 0x5 with LSU_MISALIGN_TRAP_EN → mem_wren never high, rsp_fault 1, rsp_rdata 0; without the macro → byteena 4'b1111 at word 0x1.
- Load funct3 3'b011 → rsp_fault 1 one cycle after E0, no READ_WAIT.
- Reset asserted in READ_WAIT → no rsp_valid; req_ready 0 during reset and 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM encoding,
// IO window bit positions and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_READ_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP      = 2'd2;

  // Word-address bits selecting the memory-mapped IO windows.
  localparam int IO_WIN0_BIT = 10;
  localparam int IO_WIN1_BIT = 11;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_ctx_t;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_write, input logic [2:0] f3);
    if (is_write) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
// Zero latency; no flow control.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_offset +: 8];
  // Halfword lane comes from off[1] only, so a misaligned half is silently aligned.
  assign w_half = i_word[16*i_offset[1] +: 16];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: stores respond 1 cycle after acceptance, loads READ_LATENCY+1; one request
// in flight, req_ready low until the response cycle ends. Misalignment trap via LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  ld_ctx_t     r_ctx;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_fault;

  logic [1:0]  w_off;
  logic        w_accept;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_ext;
  logic        w_unused_addr;

  assign w_off    = req_address[1:0];
  assign w_accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = f3_illegal(req_write, req_funct3) || w_misalign;

  // The memory registers its inputs, so the request fields drive it directly.
  assign req_ready     = (r_state == ST_IDLE) && !reset;
  assign mem_address   = req_address[ADDR_WIDTH+1:2];
  assign mem_wren      = w_accept && req_write && !w_fault;
  assign w_unused_addr = &{1'b0, req_address[31:ADDR_WIDTH+2]};

  always_comb begin
    mem_byteena = 4'b1111;
    mem_data    = req_wdata;
    if (req_write) begin
      case (req_funct3[1:0])
        2'b00: begin
          mem_byteena = 4'b0001 << w_off;
          mem_data    = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          mem_byteena = w_off[1] ? 4'b1100 : 4'b0011;
          mem_data    = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_byteena = 4'b1111;
          mem_data    = req_wdata;
        end
      endcase
    end
  end

  load_extract u_extract (
    .i_word   (mem_q),
    .i_offset (r_ctx.off),
    .i_funct3 (r_ctx.funct3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_ctx       <= '0;
      r_rsp_rdata <= 32'h0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= 3'd0;
            if (w_fault || req_write) begin
              r_state     <= ST_RESP;
              r_rsp_fault <= w_fault;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state     <= ST_READ_WAIT;
              r_rsp_fault <= 1'b0;
              r_ctx       <= '{funct3: req_funct3, off: w_off};
            end
          end
        end
        ST_READ_WAIT: begin
          // mem_q is valid on the READ_LATENCY-th edge after acceptance.
          if (r_cnt == LAT_LAST) begin
            r_rsp_rdata <= w_ext;
            r_state     <= ST_RESP;
            r_cnt       <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a latency-accurate memory model.
module tb_load_store_unit;

  localparam int AW = 12;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_address = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_fault;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data;
  logic          mem_wren;
  logic [31:0]   mem_q;

  load_store_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] next_word = 32'h0;

  // Memory model: the word for an accepted load is visible only in the cycle
  // just before the READ_LATENCY-th edge after acceptance; junk otherwise.
  logic        acc_load_n = 1'b0;
  logic        mem_pend = 1'b0;
  int          mem_k = 0;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] junk = 32'hDEAD_BEEF;

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    junk <= $urandom;
    if (reset) begin
      mem_pend <= 1'b0;
    end else if (acc_load_n) begin
      mem_pend <= 1'b1;
      mem_k    <= 0;
      mem_word <= next_word;
    end else if (mem_pend) begin
      if (mem_k == RL - 1) mem_pend <= 1'b0;
      else mem_k <= mem_k + 1;
    end
  end

  assign mem_q = (mem_pend && mem_k == RL - 1) ? mem_word : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ref_fault(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) bad = 1'b1;
    if (f3 == 3'd2 && off != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    if (!wr) return 4'hF;
    case (f3)
      3'd0:    return 4'(1 << off);
      3'd1:    return (off >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    logic was_reset;
    logic acc, f, wr;
    logic [1:0] off;
    exp_t e;
    was_reset = 1'b0;
    @(posedge clock);
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("wren_in_reset", 32'(mem_wren), 32'd0);
        if (was_reset) begin
          check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
          check("rst_rsp_rdata", rsp_rdata, 32'h0);
          check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        end
        sb.delete();
        acc_load_n = 1'b0;
        was_reset = 1'b1;
        continue;
      end
      was_reset = 1'b0;
      check("req_ready", 32'(req_ready), 32'(sb.size() == 0));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
          check("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
      acc = req_valid && req_ready;
      wr  = req_write;
      off = req_address[1:0];
      if (acc) begin
        f = ref_fault(wr, req_funct3, off);
        check("mem_address", 32'(mem_address), (req_address >> 2) & ((32'd1 << AW) - 1));
        check("mem_wren", 32'(mem_wren), 32'(wr && !f));
        if (!f) check("mem_byteena", 32'(mem_byteena), 32'(ref_be(wr, req_funct3, off)));
        if (!f && wr) check("mem_data", mem_data, ref_data(req_funct3, req_wdata));
        e.fault = f;
        e.rdata = (f || wr) ? 32'h0 : ref_load(req_funct3, off, next_word);
        e.due   = cyc + 1 + ((f || wr) ? 0 : RL);
        sb.push_back(e);
      end else begin
        check("mem_wren_idle", 32'(mem_wren), 32'd0);
      end
      acc_load_n = acc && !wr;
    end
  end

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] word);
    int t;
    @(negedge clock);
    next_word   = word;
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_address = addr;
    req_wdata   = wd;
    t = 0;
    #1;
    while (!req_ready && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    issue(1'b1, 3'd0, 32'h0000_0406, 32'h0000_00A5, 32'h0);   // SB lane 2
    issue(1'b0, 3'd0, 32'h0000_0003, 32'h0, 32'h80FF_0000);   // LB
    issue(1'b0, 3'd4, 32'h0000_0003, 32'h0, 32'h80FF_0000);   // LBU
    issue(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h8001_1234);   // LH upper
    issue(1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'hC0DE_F00D);   // LW IO window
    issue(1'b1, 3'd2, 32'h0000_0005, 32'h1234_5678, 32'h0);   // SW misaligned
    issue(1'b0, 3'd1, 32'h0000_0001, 32'h0, 32'h0000_8765);   // LH misaligned
    issue(1'b0, 3'd3, 32'h0000_0010, 32'h0, 32'h0);           // illegal load funct3
    issue(1'b1, 3'd5, 32'h0000_0010, 32'h0, 32'h0);           // illegal store funct3
    issue(1'b1, 3'd1, 32'h0000_0802, 32'hBEEF_CAFE, 32'h0);   // SH upper half

    // Reset while the load is in READ_WAIT: no response may follow.
    issue(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1111_2222);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (RL + 3) @(negedge clock);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d responses still outstanding", sb.size());
    end
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
